fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_decode.sv | 22 ++
 rtl/fetch_sequencer.sv | 115 +++++++++++
 tb/tb_fetch_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch path.
//   state_e : fetch sequencer FSM encoding (FETCH, WAIT, ISSUE, HALT)
//   OP_JMP  : default opcode (top nibble) for an absolute jump
//   OP_HLT  : default opcode (top nibble) for halt
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [3:0] OP_JMP = 4'hF;
  localparam logic [3:0] OP_HLT = 4'h0;

endpackage

// File: rtl/fetch_decode.sv
// Combinational opcode decode of the captured instruction.
// Ports:
//   instr_i  : captured instruction (W bits), opcode in the top nibble
//   is_jmp_o : opcode equals JMP_OP
//   is_hlt_o : opcode equals HLT_OP
//   target_o : jump target, zero-extended low W-4 bits of the instruction
module fetch_decode #(
  parameter int         W      = 16,
  parameter logic [3:0] JMP_OP = 4'hF,
  parameter logic [3:0] HLT_OP = 4'h0
) (
  input  logic [W-1:0] instr_i,
  output logic         is_jmp_o,
  output logic         is_hlt_o,
  output logic [W-1:0] target_o
);

  assign is_jmp_o = (instr_i[W-1:W-4] == JMP_OP);
  assign is_hlt_o = (instr_i[W-1:W-4] == HLT_OP);
  assign target_o = {4'b0000, instr_i[W-5:0]};

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer driving an external loadable program counter.
// The counter increments whenever pc_load is low, so this block holds the PC
// (pc_load=1, pc_target=pc_in) in every cycle except an accepted advance.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   pc_in        : current PC from the counter
//   pc_load      : counter load strobe (0 = increment)
//   pc_target    : counter load value
//   mem_req      : instruction memory read request
//   mem_addr     : read address (always the current PC)
//   mem_ack      : single-cycle read-data-valid pulse
//   mem_rdata    : read data
//   instr_valid  : instruction presented downstream
//   instr_out    : captured instruction
//   instr_ready  : downstream accepts the instruction
//   halted       : stopped on a halt instruction
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int         W      = 16,
  parameter logic [3:0] JMP_OP = OP_JMP,
  parameter logic [3:0] HLT_OP = OP_HLT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pc_in,
  output logic         pc_load,
  output logic [W-1:0] pc_target,
  output logic         mem_req,
  output logic [W-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata,
  output logic         instr_valid,
  output logic [W-1:0] instr_out,
  input  logic         instr_ready,
  output logic         halted
);

  state_e         state_q, state_d;
  logic [W-1:0]   instr_q;
  logic           mem_req_q;
  logic           instr_valid_q;
  logic           halted_q;

  logic           is_jmp;
  logic           is_hlt;
  logic [W-1:0]   jmp_target;
  logic           accept;

  // Decode works only on the registered instruction, so mem_rdata never
  // reaches pc_load combinationally.
  fetch_decode #(
    .W      (W),
    .JMP_OP (JMP_OP),
    .HLT_OP (HLT_OP)
  ) u_decode (
    .instr_i  (instr_q),
    .is_jmp_o (is_jmp),
    .is_hlt_o (is_hlt),
    .target_o (jmp_target)
  );

  assign accept = (state_q == ISSUE) && instr_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = WAIT;
      WAIT:    if (mem_ack) state_d = ISSUE;
      ISSUE:   if (instr_ready) state_d = is_hlt ? HALT : FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Flag outputs are registered from the next state. The FETCH cycle that
  // directly follows reset therefore has mem_req low; the request rises on
  // the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      instr_q       <= '0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      if ((state_q == WAIT) && mem_ack) begin
        instr_q <= mem_rdata;
      end
      mem_req_q     <= (state_d == FETCH) || (state_d == WAIT);
      instr_valid_q <= (state_d == ISSUE);
      halted_q      <= (state_d == HALT);
    end
  end

  // Hold by default; an accepted jump loads the target, an accepted ordinary
  // instruction releases the load for one cycle. An accepted halt holds.
  always_comb begin
    pc_load   = 1'b1;
    pc_target = pc_in;
    if (accept && is_jmp) begin
      pc_target = jmp_target;
    end else if (accept && !is_hlt) begin
      pc_load = 1'b0;
    end
  end

  assign mem_addr    = pc_in;
  assign mem_req     = mem_req_q;
  assign instr_valid = instr_valid_q;
  assign instr_out   = instr_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic        instr_ready;
  logic        halted;

  // Bench-side override so the counter can be preset (used for the wrap case).
  logic        pc_set_en;
  logic [15:0] pc_set_val;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // External program counter: async reset to 0, load or increment.
  always @(posedge clk or posedge reset) begin
    if (reset)          pc <= 16'h0000;
    else if (pc_set_en) pc <= pc_set_val;
    else if (pc_load)   pc <= pc_target;
    else                pc <= pc + 16'h0001;
  end

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .instr_ready (instr_ready),
    .halted      (halted)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    int          ack_dly;
    int          rdy_dly;
    logic        exp_load;
    logic        chk_tgt;
    logic [15:0] exp_tgt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered at a negedge with the DUT in WAIT; returns at the negedge after
  // the accept cycle (FETCH or HALT).
  task automatic txn(input logic [15:0] addr, input logic [15:0] instr,
                     input int ack_dly, input int rdy_dly,
                     input logic exp_load, input logic chk_tgt, input logic [15:0] exp_tgt);
    logic [15:0] pc0;
    pc0 = pc;
    chk("wait_req", mem_req, 1'b1);
    chk("wait_addr", mem_addr, addr);
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      chk("slow_req", mem_req, 1'b1);
      chk("slow_addr", mem_addr, addr);
      chk("slow_pc", pc, pc0);
      chk("slow_valid", instr_valid, 1'b0);
    end
    mem_ack   = 1'b1;
    mem_rdata = instr;
    #1 chk("ack_pc_load", pc_load, 1'b1);
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 16'(~instr);
    chk("issue_valid", instr_valid, 1'b1);
    chk("issue_instr", instr_out, instr);
    chk("issue_req", mem_req, 1'b0);
    for (int i = 0; i < rdy_dly; i++) begin
      // a stray ack during ISSUE must not disturb the held instruction
      mem_ack = (i == 1);
      @(negedge clk);
      chk("bp_valid", instr_valid, 1'b1);
      chk("bp_instr", instr_out, instr);
      chk("bp_pc", pc, pc0);
      chk("bp_req", mem_req, 1'b0);
    end
    mem_ack     = 1'b0;
    instr_ready = 1'b1;
    #1 chk("accept_load", pc_load, exp_load);
    if (chk_tgt) chk("accept_target", pc_target, exp_tgt);
    @(negedge clk);
    instr_ready = 1'b0;
    $display("[TB] txn addr=%h instr=%h ack_dly=%0d rdy_dly=%0d pc_now=%h", addr, instr, ack_dly, rdy_dly, pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0000, 16'h1234, 0, 0, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{16'h0001, 16'h5678, 1, 0, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{16'h0002, 16'hF0A5, 0, 0, 1'b1, 1'b1, 16'h00A5};
    vecs[3] = '{16'h00A5, 16'hA000, 7, 0, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{16'h00A6, 16'h3FFF, 0, 5, 1'b0, 1'b0, 16'h0000};
    vecs[5] = '{16'h00A7, 16'hFFFF, 0, 0, 1'b1, 1'b1, 16'h0FFF};
    vecs[6] = '{16'h0FFF, 16'h8001, 2, 1, 1'b0, 1'b0, 16'h0000};
    vecs[7] = '{16'h1000, 16'hF000, 0, 0, 1'b1, 1'b1, 16'h0000};

    reset       = 1'b1;
    mem_ack     = 1'b0;
    mem_rdata   = 16'h0000;
    instr_ready = 1'b0;
    pc_set_en   = 1'b0;
    pc_set_val  = 16'h0000;

    repeat (3) @(negedge clk);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_instr", instr_out, 16'h0000);
    chk("rst_load", pc_load, 1'b1);
    chk("rst_target", pc_target, pc);
    reset = 1'b0;
    @(negedge clk);
    // first edge after release raises the request
    chk("first_req", mem_req, 1'b1);

    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        chk("fetch_req", mem_req, 1'b1);
        chk("fetch_addr", mem_addr, vecs[i].addr);
        chk("fetch_valid", instr_valid, 1'b0);
        @(negedge clk);
      end
      txn(vecs[i].addr, vecs[i].instr, vecs[i].ack_dly, vecs[i].rdy_dly,
          vecs[i].exp_load, vecs[i].chk_tgt, vecs[i].exp_tgt);
    end
    chk("loop_end_addr", mem_addr, 16'h0000);

    // Wrap: preset PC to FFFF, advance must land on 0000.
    pc_set_en  = 1'b1;
    pc_set_val = 16'hFFFF;
    @(negedge clk);
    pc_set_en  = 1'b0;
    txn(16'hFFFF, 16'h1111, 0, 0, 1'b0, 1'b0, 16'h0000);
    chk("wrap_addr", mem_addr, 16'h0000);
    chk("wrap_req", mem_req, 1'b1);
    @(negedge clk);

    // Halt: hold PC, then silence for 20 cycles even with a stray ack.
    txn(16'h0000, 16'h0000, 0, 0, 1'b1, 1'b1, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      mem_ack = (i == 3);
      chk("halt_flag", halted, 1'b1);
      chk("halt_req", mem_req, 1'b0);
      chk("halt_valid", instr_valid, 1'b0);
      chk("halt_pc", pc, 16'h0000);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    $display("[TB] halt held for 20 cycles, halted=%b", halted);

    // Reset out of HALT, then reset again in the middle of WAIT.
    reset = 1'b1;
    #1 chk("rst_halt_clear", halted, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("w_req", mem_req, 1'b1);
    chk("w_addr", mem_addr, 16'h0000);
    reset = 1'b1;
    #1 chk("midwait_req", mem_req, 1'b0);
    chk("midwait_load", pc_load, 1'b1);
    chk("midwait_target", pc_target, pc);
    @(negedge clk);
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_ack   = 1'b0;
    chk("stray_valid", instr_valid, 1'b0);
    chk("stray_instr", instr_out, 16'h0000);
    $display("[TB] reset mid-WAIT with stray ack, instr_valid=%b", instr_valid);
    txn(16'h0000, 16'h4321, 0, 0, 1'b0, 1'b0, 16'h0000);
    chk("post_rst_addr", mem_addr, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
